// File: rtl/adv_div_pkg.sv
// Shared definitions for the adv_div restoring divider: datapath width,
// FSM state encoding and the quotient value reported on an error result.
package adv_div_pkg;

    localparam int DW = 32;

    localparam logic [DW-1:0] ERR_QUOT = 32'hFFFF_FFFF;

    typedef enum logic {
        IDLE = 1'b0,
        CALC = 1'b1
    } state_t;

    // Iteration counter width: one spare bit so the count past the last
    // iteration never wraps.
    function automatic int cnt_width(input int spc);
        return $clog2(DW / spc) + 1;
    endfunction

endpackage

// File: rtl/adv_div_div_step.sv
// One restoring division step: shift the next dividend bit into the partial
// remainder, subtract the divisor when it fits, record the quotient bit.
module div_step
    import adv_div_pkg::*;
(
    input  logic [DW-1:0] i_rem,
    input  logic [DW-1:0] i_quot,
    input  logic [DW-1:0] i_divisor,
    output logic [DW-1:0] o_rem,
    output logic [DW-1:0] o_quot
);

    // The shifted remainder needs DW+1 bits; the incoming remainder is always
    // below the divisor, so after a successful subtract it fits in DW bits again.
    logic [DW:0] w_shift;
    logic        w_ge;

    assign w_shift = {i_rem, i_quot[DW-1]};
    assign w_ge    = (w_shift >= {1'b0, i_divisor});

    // Conditional subtract and quotient-bit insertion.
    always_comb begin
        o_quot = {i_quot[DW-2:0], w_ge};
        o_rem  = w_shift[DW-1:0];
        if (w_ge) begin
            o_rem = w_shift[DW-1:0] - i_divisor;
        end
    end

endmodule

// File: rtl/adv_div.sv
// Iterative radix-2 restoring divider: 64-bit dividend / 32-bit divisor ->
// 32-bit quotient and remainder, SPC quotient bits per clock, one op in flight.
//
//  state | meaning
//  ------+-----------------------------------------------------------------
//  IDLE  | ready for a request; illegal requests are answered from here
//  CALC  | iterating; new requests are ignored until the result strobe
module adv_div
    import adv_div_pkg::*;
#(
    parameter int SPC = 1
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2*DW-1:0]   in_dividend,
    input  logic [DW-1:0]     in_divisor,
    output logic              out_valid,
    output logic [DW-1:0]     out_quot,
    output logic [DW-1:0]     out_rem,
    output logic              out_err
);

    localparam int            ITERS    = DW / SPC;
    localparam int            CW       = cnt_width(SPC);
    localparam logic [CW-1:0] LAST_CNT = CW'(ITERS - 1);

    state_t          r_state;
    state_t          w_state_nxt;
    logic [CW-1:0]   r_cnt;
    logic [DW-1:0]   r_rem;
    logic [DW-1:0]   r_quot;

    logic            w_accept;
    logic            w_illegal;
    logic            w_last;

    logic [DW-1:0]   w_rem_chain  [0:SPC];
    logic [DW-1:0]   w_quot_chain [0:SPC];

    assign w_accept = in_valid && in_ready;
    // A quotient needs more than DW bits exactly when the high dividend word
    // is not below the divisor; a zero divisor always lands here too.
    assign w_illegal = (in_divisor == '0) || (in_dividend[2*DW-1:DW] >= in_divisor);
    assign w_last    = (r_cnt == LAST_CNT);

    assign w_rem_chain[0]  = r_rem;
    assign w_quot_chain[0] = r_quot;

    for (genvar g = 0; g < SPC; g++) begin : g_step
        div_step u_step (
            .i_rem     (w_rem_chain[g]),
            .i_quot    (w_quot_chain[g]),
            .i_divisor (in_divisor_q(g)),
            .o_rem     (w_rem_chain[g+1]),
            .o_quot    (w_quot_chain[g+1])
        );
    end

    // The divisor must stay stable for the whole op, but the input bus is
    // free to change once accepted, so it is captured at accept.
    logic [DW-1:0] r_divisor;

    function automatic logic [DW-1:0] in_divisor_q(input int idx);
        return (idx >= 0) ? r_divisor : r_divisor;
    endfunction

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept && !w_illegal) begin
                    w_state_nxt = CALC;
                end
            end
            CALC: begin
                if (w_last) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // FSM outputs.
    always_comb begin
        in_ready = 1'b0;
        if (r_state == IDLE) begin
            in_ready = 1'b1;
        end
    end

    // Operand capture, iteration registers, counter and result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt     <= '0;
            r_rem     <= '0;
            r_quot    <= '0;
            r_divisor <= '0;
            out_valid <= 1'b0;
            out_quot  <= '0;
            out_rem   <= '0;
            out_err   <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        if (w_illegal) begin
                            out_valid <= 1'b1;
                            out_quot  <= ERR_QUOT;
                            out_rem   <= '0;
                            out_err   <= 1'b1;
                        end else begin
                            r_rem     <= in_dividend[2*DW-1:DW];
                            r_quot    <= in_dividend[DW-1:0];
                            r_divisor <= in_divisor;
                            r_cnt     <= '0;
                        end
                    end
                end
                CALC: begin
                    r_rem  <= w_rem_chain[SPC];
                    r_quot <= w_quot_chain[SPC];
                    r_cnt  <= r_cnt + CW'(1);
                    if (w_last) begin
                        out_valid <= 1'b1;
                        out_quot  <= w_quot_chain[SPC];
                        out_rem   <= w_rem_chain[SPC];
                        out_err   <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_adv_div.sv
// Self-checking bench for adv_div: SPC=1 and SPC=4 instances, directed
// vectors, flow/reset sequences and random traffic against a cycle model.
module tb_adv_div;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        iv  [2];
    logic [63:0] dd  [2];
    logic [31:0] ds  [2];
    logic        rdy [2];
    logic        ov  [2];
    logic        e   [2];
    logic [31:0] q   [2];
    logic [31:0] r   [2];

    int errors = 0;
    int checks = 0;
    bit mon_en = 1'b0;

    always #5 clk = ~clk;

    adv_div #(.SPC(1)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(rdy[0]),
        .in_dividend(dd[0]), .in_divisor(ds[0]), .out_valid(ov[0]),
        .out_quot(q[0]), .out_rem(r[0]), .out_err(e[0])
    );

    adv_div #(.SPC(4)) u_dut4 (
        .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(rdy[1]),
        .in_dividend(dd[1]), .in_divisor(ds[1]), .out_valid(ov[1]),
        .out_quot(q[1]), .out_rem(r[1]), .out_err(e[1])
    );

    function automatic int lat_of(input int d);
        return (d == 0) ? 32 : 8;
    endfunction

    task automatic chk(input string nm, input int d, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d: got %h expected %h at %0t", nm, d, act, exp, $time);
        end
    endtask

    // Transaction-level reference: an accepted legal op makes the unit busy
    // for LAT edges and then reports dividend/divisor; an op whose quotient
    // does not fit 32 bits (or divides by zero) is answered on the accept edge.
    int          m_busy [2];
    logic        m_ov   [2];
    logic        m_e    [2];
    logic [31:0] m_q    [2];
    logic [31:0] m_r    [2];
    logic [31:0] pq     [2];
    logic [31:0] pr     [2];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int d = 0; d < 2; d++) begin
                m_busy[d] <= 0;
                m_ov[d]   <= 1'b0;
                m_e[d]    <= 1'b0;
                m_q[d]    <= '0;
                m_r[d]    <= '0;
                pq[d]     <= '0;
                pr[d]     <= '0;
            end
        end else begin
            for (int d = 0; d < 2; d++) begin
                m_ov[d] <= 1'b0;
                if (m_busy[d] > 0) begin
                    m_busy[d] <= m_busy[d] - 1;
                    if (m_busy[d] == 1) begin
                        m_ov[d] <= 1'b1;
                        m_q[d]  <= pq[d];
                        m_r[d]  <= pr[d];
                        m_e[d]  <= 1'b0;
                    end
                end else if (iv[d]) begin
                    if (ds[d] == 0) begin
                        m_ov[d] <= 1'b1; m_q[d] <= 32'hFFFF_FFFF; m_r[d] <= '0; m_e[d] <= 1'b1;
                    end else if ((dd[d] / {32'b0, ds[d]}) > 64'hFFFF_FFFF) begin
                        m_ov[d] <= 1'b1; m_q[d] <= 32'hFFFF_FFFF; m_r[d] <= '0; m_e[d] <= 1'b1;
                    end else begin
                        m_busy[d] <= lat_of(d);
                        pq[d]     <= 32'(dd[d] / {32'b0, ds[d]});
                        pr[d]     <= 32'(dd[d] % {32'b0, ds[d]});
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (mon_en) begin
            for (int d = 0; d < 2; d++) begin
                chk("mon_ready", d, 64'(rdy[d]), 64'(m_busy[d] == 0));
                chk("mon_valid", d, 64'(ov[d]), 64'(m_ov[d]));
                chk("mon_quot",  d, 64'(q[d]),  64'(m_q[d]));
                chk("mon_rem",   d, 64'(r[d]),  64'(m_r[d]));
                chk("mon_err",   d, 64'(e[d]),  64'(m_e[d]));
            end
        end
    end

    typedef struct {
        logic [63:0] dividend;
        logic [31:0] divisor;
        logic [31:0] quot;
        logic [31:0] rem;
        logic        err;
    } vec_t;

    vec_t vecs [10];

    // Called right after a negedge with the DUT idle; returns at the negedge
    // where the result strobe is seen.
    task automatic run_vec(input int d, input vec_t v);
        bit got;
        got = 1'b0;
        iv[d] = 1'b1;
        dd[d] = v.dividend;
        ds[d] = v.divisor;
        for (int k = 1; k <= 45 && !got; k++) begin
            @(negedge clk);
            iv[d] = 1'b0;
            if (k == 1) chk(v.err ? "err_ready_held" : "busy_ready_low", d, 64'(rdy[d]), v.err ? 64'd1 : 64'd0);
            if (ov[d]) begin
                got = 1'b1;
                chk("vec_quot", d, 64'(q[d]), 64'(v.quot));
                chk("vec_rem",  d, 64'(r[d]), 64'(v.rem));
                chk("vec_err",  d, 64'(e[d]), 64'(v.err));
                chk("vec_latency", d, 64'(k - 1), v.err ? 64'd0 : 64'(lat_of(d)));
            end
        end
        if (!got) chk("vec_timeout", d, 64'd0, 64'd1);
    endtask

    task automatic flow(input int d);
        int strobes;
        int lat;
        strobes = 0;
        lat = lat_of(d);
        iv[d] = 1'b1; dd[d] = 64'd100; ds[d] = 32'd7;
        @(negedge clk);
        dd[d] = 64'h0000_0000_0007_0000; ds[d] = 32'h0001_0000;
        for (int k = 2; k <= 2 * lat + 12; k++) begin
            @(negedge clk);
            if (k == lat + 2) begin
                chk("flow_b_busy", d, 64'(rdy[d]), 64'd0);
                iv[d] = 1'b0;
            end
            if (ov[d]) begin
                strobes++;
                if (strobes == 1) begin
                    chk("flow_a_quot", d, 64'(q[d]), 64'd14);
                    chk("flow_a_rem",  d, 64'(r[d]), 64'd2);
                    chk("flow_a_lat",  d, 64'(k - 1), 64'(lat));
                    chk("flow_ready_at_strobe", d, 64'(rdy[d]), 64'd1);
                end else if (strobes == 2) begin
                    chk("flow_b_quot", d, 64'(q[d]), 64'd7);
                    chk("flow_b_rem",  d, 64'(r[d]), 64'd0);
                    chk("flow_b_lat",  d, 64'(k - 1), 64'(2 * lat + 1));
                end
            end
        end
        chk("flow_strobes", d, 64'(strobes), 64'd2);
    endtask

    task automatic reset_mid();
        int   strobes;
        vec_t v;
        strobes = 0;
        iv[0] = 1'b1; dd[0] = 64'd1000; ds[0] = 32'd3;
        @(negedge clk);
        iv[0] = 1'b0;
        repeat (9) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("rstmid_valid", d, 64'(ov[d]), 64'd0);
            chk("rstmid_quot",  d, 64'(q[d]),  64'd0);
            chk("rstmid_rem",   d, 64'(r[d]),  64'd0);
            chk("rstmid_err",   d, 64'(e[d]),  64'd0);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rstmid_ready", 0, 64'(rdy[0]), 64'd1);
        repeat (40) begin
            @(negedge clk);
            if (ov[0]) strobes++;
        end
        chk("rstmid_no_stale", 0, 64'(strobes), 64'd0);
        v = '{64'd1000, 32'd3, 32'd333, 32'd1, 1'b0};
        run_vec(0, v);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] div_r;
        logic [31:0] hi_r;
        int          sel;

        for (int d = 0; d < 2; d++) begin
            iv[d] = 1'b0; dd[d] = '0; ds[d] = '0;
        end
        vecs[0] = '{64'd100,                 32'd7,            32'd14,           32'd2, 1'b0};
        vecs[1] = '{64'h0000_0000_0007_0000, 32'h0001_0000,    32'd7,            32'd0, 1'b0};
        vecs[2] = '{64'hFFFF_FFFE_0000_0001, 32'hFFFF_FFFF,    32'hFFFF_FFFF,    32'd0, 1'b0};
        vecs[3] = '{64'd5,                   32'd0,            32'hFFFF_FFFF,    32'd0, 1'b1};
        vecs[4] = '{64'h0000_0001_0000_0000, 32'd1,            32'hFFFF_FFFF,    32'd0, 1'b1};
        vecs[5] = '{64'd0,                   32'd3,            32'd0,            32'd0, 1'b0};
        vecs[6] = '{64'h0000_0002_0000_0000, 32'd3,            32'hAAAA_AAAA,    32'd2, 1'b0};
        vecs[7] = '{64'h0000_0009_FFFF_FFFF, 32'd10,           32'hFFFF_FFFF,    32'd9, 1'b0};
        vecs[8] = '{64'h0000_000A_0000_0000, 32'd10,           32'hFFFF_FFFF,    32'd0, 1'b1};
        vecs[9] = '{64'd1,                   32'd1,            32'd1,            32'd0, 1'b0};

        #1 rst = 1'b1;
        #1 mon_en = 1'b1;
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("reset_valid", d, 64'(ov[d]), 64'd0);
            chk("reset_quot",  d, 64'(q[d]),  64'd0);
            chk("reset_rem",   d, 64'(r[d]),  64'd0);
            chk("reset_err",   d, 64'(e[d]),  64'd0);
        end
        rst = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 2; d++) chk("reset_ready", d, 64'(rdy[d]), 64'd1);

        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 10; i++) run_vec(d, vecs[i]);
        end

        flow(0);
        flow(1);
        reset_mid();

        repeat (3000) begin
            for (int d = 0; d < 2; d++) begin
                sel = int'($urandom_range(0, 9));
                case (sel)
                    0:       div_r = 32'd0;
                    1:       div_r = 32'd1;
                    2:       div_r = 32'hFFFF_FFFF;
                    3:       div_r = $urandom_range(1, 255);
                    default: div_r = $urandom;
                endcase
                if ($urandom_range(0, 7) == 0 || div_r == 0) hi_r = $urandom;
                else hi_r = $urandom % div_r;
                iv[d] = ($urandom_range(0, 2) != 0);
                dd[d] = {hi_r, $urandom};
                ds[d] = div_r;
            end
            @(negedge clk);
        end
        for (int d = 0; d < 2; d++) iv[d] = 1'b0;
        repeat (40) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
